// File: rtl/bsr_pkg.sv
// Shared constants and encodings for the bit shift register and its cells.
// Contents: default register width, direction encoding, per-cell next-state select.
// Imported by bsr_cell and bit_shift_register5.
package bsr_pkg;

  localparam int unsigned BSR_WIDTH_DEFAULT = 5;

  typedef enum logic {
    DIR_LEFT  = 1'b0,   // serial data enters bit 0, MSB falls out
    DIR_RIGHT = 1'b1    // serial data enters bit WIDTH-1, LSB falls out
  } dir_e;

  // Next-state select shared by every cell; decoded once in the top.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_SHL  = 2'd1,
    OP_SHR  = 2'd2,
    OP_LOAD = 2'd3
  } cell_op_e;

endpackage

// File: rtl/bsr_cell.sv
// One bit of the shift register: a flop plus its hold/shift-left/shift-right/load mux.
// Ports: clk, rst_n (async active-low), op_i (shared select), left_i/right_i (neighbour
//        or serial input), pi_i (parallel bit), q_o (registered bit).
module bsr_cell
  import bsr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  cell_op_e op_i,
  input  logic     left_i,   // lower-index neighbour (or SI at bit 0)
  input  logic     right_i,  // higher-index neighbour (or SI at bit WIDTH-1)
  input  logic     pi_i,
  output logic     q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case (op_i)
      OP_HOLD: q_d = q_q;
      OP_SHL:  q_d = left_i;
      OP_SHR:  q_d = right_i;
      OP_LOAD: q_d = pi_i;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_BIT;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/bit_shift_register5.sv
// Bidirectional serial-in / parallel-in shift register built from WIDTH bsr_cell instances.
// Ports: clk, rst (async active-low), SI, shift_en, dir, load, PI -> SO (flops), SOUT (comb on dir).
// Optional PARITY output (registered XOR of SO) when BIT_SHIFT_REGISTER5_PARITY_EN is defined.
module bit_shift_register5
  import bsr_pkg::*;
#(
  parameter int unsigned            WIDTH   = BSR_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SI,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] SO,
  output logic             SOUT
`ifdef BIT_SHIFT_REGISTER5_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  cell_op_e         op;
  logic [WIDTH-1:0] so_q;

  // Load wins over shift; direction only matters when shifting.
  always_comb begin
    op = OP_HOLD;
    if (load)              op = OP_LOAD;
    else if (shift_en)     op = (dir_e'(dir) == DIR_RIGHT) ? OP_SHR : OP_SHL;
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    logic left_in;
    logic right_in;

    if (i == 0) begin : g_lsb
      assign left_in = SI;
    end else begin : g_mid_l
      assign left_in = so_q[i-1];
    end

    if (i == int'(WIDTH) - 1) begin : g_msb
      assign right_in = SI;
    end else begin : g_mid_r
      assign right_in = so_q[i+1];
    end

    bsr_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst),
      .op_i    (op),
      .left_i  (left_in),
      .right_i (right_in),
      .pi_i    (PI[i]),
      .q_o     (so_q[i])
    );
  end

  assign SO   = so_q;
  assign SOUT = (dir_e'(dir) == DIR_RIGHT) ? so_q[0] : so_q[WIDTH-1];

`ifdef BIT_SHIFT_REGISTER5_PARITY_EN
  logic parity_q;
  logic parity_d;

  // parity_q always equals ^so_q, so a shift only needs the bit leaving
  // and the bit entering folded in rather than a full WIDTH-wide XOR.
  always_comb begin
    parity_d = parity_q;
    unique case (op)
      OP_HOLD: parity_d = parity_q;
      OP_SHL:  parity_d = parity_q ^ so_q[WIDTH-1] ^ SI;
      OP_SHR:  parity_d = parity_q ^ so_q[0] ^ SI;
      OP_LOAD: parity_d = ^PI;
      default: parity_d = parity_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_q <= ^RST_VAL;
    else      parity_q <= parity_d;
  end

  assign PARITY = parity_q;
`endif

endmodule

// File: tb/tb_bit_shift_register5.sv
// Self-checking bench for bit_shift_register5 (WIDTH=5, RST_VAL=0).
// Scoreboard: expected SO/SOUT/PARITY pushed at drive time, popped after the edge.
// Define BIT_SHIFT_REGISTER5_PARITY_EN to also cover the PARITY output.
module tb_bit_shift_register5;

  localparam int W = 5;

  typedef struct packed {
    logic [W-1:0] so;
    logic         par;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         SI, shift_en, dir, load;
  logic [W-1:0] PI;
  logic [W-1:0] SO;
  logic         SOUT;
`ifdef BIT_SHIFT_REGISTER5_PARITY_EN
  logic         PARITY;
`endif

  int checks = 0;
  int errors = 0;
  exp_t         exp_q[$];
  logic [W-1:0] model;

  always #5 clk = ~clk;

  bit_shift_register5 #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .SI       (SI),
    .shift_en (shift_en),
    .dir      (dir),
    .load     (load),
    .PI       (PI),
    .SO       (SO),
    .SOUT     (SOUT)
`ifdef BIT_SHIFT_REGISTER5_PARITY_EN
    ,
    .PARITY   (PARITY)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic si, input logic sh, input logic d, input logic ld,
                      input logic [W-1:0] pi);
    exp_t e;
    exp_t got;
    @(negedge clk);
    SI = si; shift_en = sh; dir = d; load = ld; PI = pi;
    if (ld)                  model = pi;
    else if (sh && d == 1'b0) model = {model[W-2:0], si};
    else if (sh)              model = {si, model[W-1:1]};
    e.so  = model;
    e.par = ^model;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      check_val("so", 32'(SO), 32'(got.so));
      check_val("sout", 32'(SOUT), 32'(dir ? got.so[0] : got.so[W-1]));
`ifdef BIT_SHIFT_REGISTER5_PARITY_EN
      check_val("parity", 32'(PARITY), 32'(got.par));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted with shift activity present.
    rst = 1'b0; SI = 1'b1; shift_en = 1'b1; dir = 1'b0; load = 1'b0; PI = '0;
    model = '0;
    #1;
    check_val("reset_async", 32'(SO), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("reset_hold", 32'(SO), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1; shift_en = 1'b0;

    // Left shift SI=1,0,1,0.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0); check_val("shl_1", 32'(SO), 32'b00001);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0); check_val("shl_2", 32'(SO), 32'b00010);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0); check_val("shl_3", 32'(SO), 32'b00101);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0); check_val("shl_4", 32'(SO), 32'b01010);

    // Reset pulsed between edges discards contents immediately.
    #2;
    rst = 1'b0; model = '0;
    #1;
    check_val("reset_mid", 32'(SO), 32'd0);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, '0); check_val("after_reset", 32'(SO), 32'b00001);

    // Right shift from zero SI=1,1,0.
    step(1'b0, 1'b0, 1'b0, 1'b1, '0); check_val("clear", 32'(SO), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0); check_val("shr_1", 32'(SO), 32'b10000);
    check_val("shr_sout1", 32'(SOUT), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0); check_val("shr_2", 32'(SO), 32'b11000);
    check_val("shr_sout2", 32'(SOUT), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0); check_val("shr_3", 32'(SO), 32'b01100);
    check_val("shr_sout3", 32'(SOUT), 32'd0);

    // Load beats shift, then hold.
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'b10110); check_val("load_prio", 32'(SO), 32'b10110);
`ifdef BIT_SHIFT_REGISTER5_PARITY_EN
    check_val("par_load", 32'(PARITY), 32'd1);
`endif
    step(1'b1, 1'b0, 1'b1, 1'b0, '0); check_val("hold_1", 32'(SO), 32'b10110);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0); check_val("hold_2", 32'(SO), 32'b10110);
`ifdef BIT_SHIFT_REGISTER5_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, '0); check_val("par_shl_so", 32'(SO), 32'b01100);
    check_val("par_shl", 32'(PARITY), 32'd0);
`endif

    // Fill with ones (left) then zeros (right): no wrap-around.
    for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_val("fill_ones", 32'(SO), 32'b11111);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check_val("fill_zeros", 32'(SO), 32'b00000);

    // Random traffic with direction changes on arbitrary cycles.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 7) == 0), W'($urandom));
    end

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
